// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   arb_state_e : FSM state encodings (IDLE / grant port 0 / grant port 1)
//   ARB_RR, ARB_FIXED : arbitration mode codes for the PRIORITY parameter
//   hold_cnt_w() : width of the per-grant hold counter
package arb_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

  localparam int unsigned ARB_RR    = 0;
  localparam int unsigned ARB_FIXED = 1;

  // clog2(max_hold), never narrower than one bit.
  function automatic int unsigned hold_cnt_w(input int unsigned max_hold);
    return (max_hold > 1) ? $clog2(max_hold) : 1;
  endfunction

endpackage

// File: rtl/arb_hold_cnt.sv
// Per-grant transfer counter for the data-memory arbiter.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset
//   clr_i      : clear (grant changed); wins over increment
//   inc_i      : one transfer happened this cycle
//   at_limit_o : counter has reached MAX_HOLD-1 (where it saturates)
module arb_hold_cnt
  import arb_defs::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_limit_o
);

  localparam int unsigned       CNT_W = hold_cnt_w(MAX_HOLD);
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign at_limit_o = (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_limit_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data RAM (async read, sync write).
// Port 0 is the CPU load/store path, port 1 the DMA / program-loader path.
//   clk, rst                : clock, synchronous active-high reset
//   reqN, lockN, weN        : request, burst lock, write(1)/read(0)
//   addrN, wdatN            : access address and write data
//   gnt0, gnt1              : registered grants (one-hot or zero)
//   rdat, rvalid0, rvalid1  : registered read data, one-cycle valid per port
//   mem_add, mem_din, mem_we: RAM pins, driven from the port transferring now
//   mem_dout                : RAM asynchronous read data
module dmem_arbiter
  import arb_defs::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned PRIORITY = ARB_RR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdat0,
  input  logic [DATA_W-1:0] wdat1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdat,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [ADDR_W-1:0] mem_add,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam bit FIXED = (PRIORITY == ARB_FIXED);

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;     // 0: port 0 granted most recently
  logic [DATA_W-1:0] rdat_q, rdat_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic              xfer0, xfer1;
  logic              rd0, rd1;
  logic              hold_at_limit;

  assign gnt0    = (state_q == ST_GNT0);
  assign gnt1    = (state_q == ST_GNT1);
  assign rdat    = rdat_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;

  assign xfer0 = gnt0 & req0;
  assign xfer1 = gnt1 & req1;
  assign rd0   = xfer0 & ~we0;
  assign rd1   = xfer1 & ~we1;

  // RAM pins follow the transferring port; rst gates the write strobe in
  // the same cycle so an access caught by reset never commits.
  always_comb begin
    mem_add = '0;
    mem_din = '0;
    mem_we  = 1'b0;
    if (xfer0) begin
      mem_add = addr0;
      mem_din = wdat0;
      mem_we  = we0 & ~rst;
    end else if (xfer1) begin
      mem_add = addr1;
      mem_din = wdat1;
      mem_we  = we1 & ~rst;
    end
  end

  always_comb begin
    rdat_d    = rdat_q;
    rvalid0_d = rd0;
    rvalid1_d = rd1;
    if (rd0 | rd1) begin
      rdat_d = mem_dout;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req0 && req1) begin
          state_d = (FIXED || last_q) ? ST_GNT0 : ST_GNT1;
        end else if (req0) begin
          state_d = ST_GNT0;
        end else if (req1) begin
          state_d = ST_GNT1;
        end
      end
      ST_GNT0: begin
        if (!req0) begin
          state_d = req1 ? ST_GNT1 : ST_IDLE;
        end else if (lock0) begin
          state_d = ST_GNT0;
        end else if (req1 && hold_at_limit) begin
          state_d = ST_GNT1;
        end
      end
      ST_GNT1: begin
        if (!req1) begin
          state_d = req0 ? ST_GNT0 : ST_IDLE;
        end else if (lock1) begin
          state_d = ST_GNT1;
        end else if (FIXED && req0) begin
          state_d = ST_GNT0;
        end else if (req0 && hold_at_limit) begin
          state_d = ST_GNT0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (state_d == ST_GNT0) begin
      last_d = 1'b0;
    end else if (state_d == ST_GNT1) begin
      last_d = 1'b1;
    end
  end

  arb_hold_cnt #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_cnt (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (state_d != state_q),
    .inc_i      (xfer0 | xfer1),
    .at_limit_o (hold_at_limit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      last_q    <= 1'b1;
      rdat_q    <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      rdat_q    <= rdat_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 256x16 data RAM (asynchronous read, synchronous write) between two requesters.
- Port 0 is the CPU load/store path; port 1 is the DMA/program-loader path.
- Uses registered grants, round-robin or fixed priority, a per-grant hold limit and a lock for bursts.
- Drives the RAM address, data-in and write-enable pins directly and returns registered read data with a valid strobe.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 16, data width.
- MAX_HOLD, 4, transfer cycles a grant may keep before it is forced to rotate if the other port requests. Must be at least 1.
- PRIORITY, 0, arbitration mode. 0 = round-robin; 1 = port 0 fixed priority.

Ports:
- clk  in  1  Clock. Single clock domain.
- rst  in  1  Reset. Synchronous, active-high.
- req0, req1  in  1  Access request. Held high while the requester has accesses pending.
- lock0, lock1  in  1  Burst lock. While high together with req, the grant is never taken away.
- we0, we1  in  1  1 = write, 0 = read.
- addr0, addr1  in  ADDR_W  Access address.
- wdat0, wdat1  in  DATA_W  Write data.
- gnt0, gnt1  out  1  Registered grant. One-hot or zero.
- rdat  out  DATA_W  Registered read data, shared by both ports.
- rvalid0, rvalid1  out  1  rdat holds this port's read result. One-cycle pulse.
- mem_add  out  ADDR_W  To RAM address.
- mem_din  out  DATA_W  To RAM data-in.
- mem_we  out  1  To RAM write enable.
- mem_dout  in  DATA_W  From RAM, asynchronous read data.

Behaviour:
- States: IDLE, GNT0, GNT1. gnt0 = (state==GNT0) and gnt1 = (state==GNT1). Both come straight from state registers.
- Transfer definition: a transfer happens in any cycle where gntX & reqX. In that cycle the RAM pins are driven combinationally from port X: mem_add=addrX, mem_din=wdatX, mem_we=weX & ~rst.
- With no transfer, mem_add=0, mem_din=0 and mem_we=0.
- Read return: a read transfer captures mem_dout into rdat at the clock edge. rvalidX=1 for exactly the next cycle. Latency is 1 cycle from the transfer to data.
- Write return: a write produces no rvalid. rdat holds its value when there is no read.
- Grant latency: a request seen in IDLE is granted on the next cycle. Switching GNT0<->GNT1 takes zero bubble cycles: the old port transfers in the last cycle and the new port is granted in the next cycle.
- last register records the most recently granted port.
- IDLE transitions:
  - Both req high: grant the port that is not last under round-robin; grant port 0 when PRIORITY=1.
  - Only one req high: grant that port.
  - Otherwise stay in IDLE.
- GNTX transitions, evaluated in this order:
  1. reqX=0: move to GNT of the other port if it requests, else to IDLE.
  2. reqX & lockX: stay.
  3. PRIORITY=1, X=1 and req0: go to GNT0 (preemption).
  4. Other port requests and hold_cnt==MAX_HOLD-1: go to GNT of the other port.
  5. Otherwise stay.
- hold_cnt: counts transfers in the current grant. It clears on every state change, saturates at MAX_HOLD-1, and has width clog2(MAX_HOLD) with a minimum of 1.
- A locked grant ignores hold_cnt for as long as lock stays high. When lock drops, rule 4 is applied on the next evaluation.
- Requests while not granted: a requester may change addr, we or wdat while waiting. Values are sampled only in transfer cycles.
- Simultaneous req drop and other req rise: handled by rule 1 above, giving a direct hand-off.
- Reset values: state=IDLE, gnt0=gnt1=0, rvalid0=rvalid1=0, rdat=0, hold_cnt=0, last=1 (port 0 wins the first tie).
- Reset mid-access: rst high forces mem_we=0 in that same cycle, so no write commits. No rvalid is issued for a read in a reset cycle.
- Invariant: never gnt0 & gnt1. Never mem_we=1 without a transfer.

Decomposition:
- Shared package (arb_defs) holds:
  - state encodings ST_IDLE=2'd0, ST_GNT0=2'd1, ST_GNT1=2'd2;
  - PRIORITY codes ARB_RR=0 and ARB_FIXED=1.
- Port muxing and FSM live in one module.
- The hold counter is a natural small sub-module, arb_hold_cnt, with clear, increment, saturation and an at-limit flag, parameterised by MAX_HOLD.

Test Plan:
- Reset then idle: hold rst 2 cycles, no req → gnt0=gnt1=0, rvalid=0, rdat=0, mem_we=0 throughout.
- Single write then read: req0 with we0=1, addr0=8'h10, wdat0=16'hBEEF → gnt0 on cycle 1, mem_we=1 for one cycle; then read of 8'h10 → rvalid0 one cycle later with rdat=16'hBEEF.
- Round-robin contention: req0 and req1 both held continuously, MAX_HOLD=4 → grants alternate GNT0 for 4 transfers, then GNT1 for 4, with no idle cycle between; port 0 is granted first after reset.
- Lock burst: port 1 granted with lock1=1 for 10 cycles while req0 is high → gnt1 held all 10 cycles; gnt0 follows within MAX_HOLD cycles after lock1 falls.
- Fixed priority preemption: PRIORITY=1, port 1 granted, req0 rises → gnt0 asserted on the next cycle, and port 1's last transfer completes.
- Reset during write: rst asserted in the same cycle as a granted write to 8'h20 → mem_we=0; a later read of 8'h20 returns the prior value, and state returns to IDLE.
